// File: rtl/rr_fsm_arbiter.sv
// rtl/rr_fsm_arbiter.sv - round-robin grant FSM sharing one start/done resource among N_REQ requesters
//
// Optional feature macro: ARB_TIMEOUT_EN (forced release after MAX_HOLD busy cycles)
//
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   req      in   [N_REQ]    per-requester request level
//   done     in   resource finished the current transaction (1-cycle pulse)
//   gnt      out  [N_REQ]    one-hot registered grant
//   gnt_idx  out  [IW]       index of the granted requester (holds last value when idle)
//   busy     out  resource owned
//   timeout  out  1-cycle pulse on a forced release

module rr_fsm_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic                       done,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   gnt_idx,
    output logic                       busy,
    output logic                       timeout
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   sel;
    logic            any_req;
    logic            force_rel;
    logic            release_now;

    assign any_req = |req;

    // Winner search starts just above the last owner; the second pass wraps
    // to index 0 and ends on the last owner itself, so the previous owner
    // only wins when nobody else is requesting.
    always_comb begin
        logic found;
        found = 1'b0;
        sel   = ptr;
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req[IW'(j)] && (IW'(j) > ptr)) begin
                sel   = IW'(j);
                found = 1'b1;
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req[IW'(j)] && (IW'(j) <= ptr)) begin
                sel   = IW'(j);
                found = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] hold_cnt;

    // Counter is 0 during the first busy cycle, so hitting MAX_HOLD-1 here
    // means this edge ends the MAX_HOLD-th busy cycle.
    assign force_rel = (state == BUSY) && !done && (hold_cnt == CW'(MAX_HOLD - 1));
`else
    logic unused_hold;
    assign unused_hold = ^MAX_HOLD;
    assign force_rel   = 1'b0;
`endif

    assign release_now = done || force_rel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            ptr     <= IW'(N_REQ - 1);
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state   <= BUSY;
                        gnt     <= {{(N_REQ-1){1'b0}}, 1'b1} << sel;
                        gnt_idx <= sel;
                        ptr     <= sel;
                        busy    <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        timeout <= force_rel;
                        if (any_req) begin
                            // Back-to-back handover without an idle bubble.
                            gnt     <= {{(N_REQ-1){1'b0}}, 1'b1} << sel;
                            gnt_idx <= sel;
                            ptr     <= sel;
`ifdef ARB_TIMEOUT_EN
                            hold_cnt <= '0;
`endif
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
